// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: operand forwarding, load-use/branch stall-flush, multi-cycle sequencing with watchdog.
// Optional performance counters are enabled by defining EX_HAZARD_PERF_CNT_EN.
module ex_hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       rs1_E,
    input  logic [4:0]       rs2_E,
    input  logic [4:0]       rd_E,
    input  logic             memRead_E,
    input  logic [4:0]       rd_M,
    input  logic             regWrite_M,
    input  logic [4:0]       rd_W,
    input  logic             regWrite_W,
    input  logic             PCSrctE,
    input  logic             mc_req_E,
    input  logic             mc_done,
    output logic [1:0]       FowardAE,
    output logic [1:0]       FowardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             mc_start,
    output logic             mc_abort,
    output logic             mc_busy,
    output logic [1:0]       state_dbg
`ifdef EX_HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [7:0]       abort_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MC_LAUNCH = 2'd1,
        MC_WAIT   = 2'd2
    } state_t;

    localparam logic [7:0] WD_LOAD = 8'(MC_TIMEOUT - 1);

    if (MC_TIMEOUT < 2 || MC_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_params
        $error("ex_hazard_ctrl: illegal MC_TIMEOUT or CNT_W");
    end

    state_t     state;
    logic [7:0] wd_cnt;
    logic       load_use;
    logic       wd_expired;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rdm,
        input logic       wem,
        input logic [4:0] rdw,
        input logic       wew
    );
        if (wem && rdm != 5'd0 && rdm == rs)
            return 2'b10;
        else if (wew && rdw != 5'd0 && rdw == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Selects are forced to 00 while reset is held so no output toggles in reset.
    always_comb begin
        FowardAE = 2'b00;
        FowardBE = 2'b00;
        if (rst_n) begin
            FowardAE = fwd_sel(rs1_E, rd_M, regWrite_M, rd_W, regWrite_W);
            FowardBE = fwd_sel(rs2_E, rd_M, regWrite_M, rd_W, regWrite_W);
        end
    end

    assign load_use   = memRead_E && (rd_E != 5'd0) && (rd_E == rs1_D || rd_E == rs2_D);
    assign wd_expired = (wd_cnt == 8'd0);
    assign state_dbg  = state;

    always_comb begin
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        FlushM   = 1'b0;
        mc_start = 1'b0;
        mc_abort = 1'b0;
        mc_busy  = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (PCSrctE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (!mc_req_E && load_use) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                MC_LAUNCH: begin
                    mc_start = 1'b1;
                    StallF   = 1'b1;
                    StallD   = 1'b1;
                    StallE   = 1'b1;
                    FlushM   = 1'b1;
                end
                MC_WAIT: begin
                    mc_busy  = 1'b1;
                    StallF   = 1'b1;
                    StallD   = 1'b1;
                    StallE   = 1'b1;
                    FlushM   = 1'b1;
                    mc_abort = !mc_done && wd_expired;
                end
                default: ;
            endcase
        end
    end

    // Stalls are asserted through the exit cycle; release takes effect on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wd_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!PCSrctE && mc_req_E)
                        state <= MC_LAUNCH;
                end
                MC_LAUNCH: begin
                    wd_cnt <= WD_LOAD;
                    state  <= MC_WAIT;
                end
                MC_WAIT: begin
                    if (mc_done || wd_expired) begin
                        state  <= IDLE;
                        wd_cnt <= 8'd0;
                    end else begin
                        wd_cnt <= wd_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EX_HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            abort_cnt <= 8'd0;
        end else begin
            if (StallF)
                stall_cnt <= stall_cnt + 1'b1;
            if (FlushE || FlushM)
                flush_cnt <= flush_cnt + 1'b1;
            if (mc_abort)
                abort_cnt <= abort_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Randomized + directed bench for ex_hazard_ctrl against a cycle-phase reference model.
module tb_ex_hazard_ctrl;
    localparam int TO    = 8;
    localparam int CNT_W = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       memRead_E, regWrite_M, regWrite_W, PCSrctE, mc_req_E, mc_done;
    logic [1:0] FowardAE, FowardBE, state_dbg;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic       mc_start, mc_abort, mc_busy;
`ifdef EX_HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [7:0]       abort_cnt;
`endif

    ex_hazard_ctrl #(.MC_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .memRead_E(memRead_E), .rd_M(rd_M), .regWrite_M(regWrite_M),
        .rd_W(rd_W), .regWrite_W(regWrite_W), .PCSrctE(PCSrctE),
        .mc_req_E(mc_req_E), .mc_done(mc_done),
        .FowardAE(FowardAE), .FowardBE(FowardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .mc_start(mc_start), .mc_abort(mc_abort), .mc_busy(mc_busy),
        .state_dbg(state_dbg)
`ifdef EX_HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .abort_cnt(abort_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: ph = cycles since launch (0 = idle, 1 = launch cycle).
    int ph = 0;
    int exp_stall = 0, exp_flush = 0, exp_abort = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (!rst_n) return 2'b00;
        if (regWrite_M && rd_M != 0 && rd_M == rs) return 2'b10;
        if (regWrite_W && rd_W != 0 && rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ctl_vec();
        return 32'({StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_start, mc_abort, mc_busy});
    endfunction

    task automatic clear_inputs();
        {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
        {memRead_E, regWrite_M, regWrite_W, PCSrctE, mc_req_E, mc_done} = '0;
    endtask

    task automatic randomize_inputs();
        rs1_D = 5'($urandom_range(0, 7)); rs2_D = 5'($urandom_range(0, 7));
        rs1_E = 5'($urandom_range(0, 7)); rs2_E = 5'($urandom_range(0, 7));
        rd_E  = 5'($urandom_range(0, 7)); rd_M  = 5'($urandom_range(0, 7));
        rd_W  = 5'($urandom_range(0, 7));
        memRead_E  = ($urandom_range(0, 9) < 3);
        regWrite_M = ($urandom_range(0, 9) < 6);
        regWrite_W = ($urandom_range(0, 9) < 6);
        PCSrctE    = ($urandom_range(0, 99) < 15);
        mc_req_E   = ($urandom_range(0, 99) < 15);
        mc_done    = ($urandom_range(0, 99) < 15);
    endtask

    // Compare all outputs at the negedge, then advance the model to the next cycle.
    task automatic eval_cycle(input string tag);
        logic sf, sd, se, fd, fe, fm, st, ab, bz, lu;
        @(negedge clk);
        {sf, sd, se, fd, fe, fm, st, ab, bz} = '0;
        lu = memRead_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
        if (!rst_n) begin
            ph = 0; exp_stall = 0; exp_flush = 0; exp_abort = 0;
        end
        if (rst_n) begin
            if (ph == 0) begin
                if (PCSrctE) begin fd = 1; fe = 1; end
                else if (!mc_req_E && lu) begin sf = 1; sd = 1; fe = 1; end
            end else begin
                {sf, sd, se, fm} = 4'hF;
                st = (ph == 1);
                bz = (ph >= 2);
                ab = bz && !mc_done && (ph == TO + 1);
            end
        end
        check({tag, ".fwdA"}, 32'(FowardAE), 32'(fwd_ref(rs1_E)));
        check({tag, ".fwdB"}, 32'(FowardBE), 32'(fwd_ref(rs2_E)));
        check({tag, ".ctl"}, ctl_vec(), 32'({sf, sd, se, fd, fe, fm, st, ab, bz}));
        check({tag, ".idle"}, 32'(state_dbg == 2'd0), 32'(ph == 0));
`ifdef EX_HAZARD_PERF_CNT_EN
        check({tag, ".stall_cnt"}, stall_cnt, 32'(exp_stall));
        check({tag, ".flush_cnt"}, flush_cnt, 32'(exp_flush));
        check({tag, ".abort_cnt"}, 32'(abort_cnt), 32'(exp_abort % 256));
`endif
        if (rst_n) begin
            exp_stall += sf;
            exp_flush += (fe || fm);
            exp_abort += ab;
            if (ph == 0) ph = (!PCSrctE && mc_req_E) ? 1 : 0;
            else if (ph == 1) ph = 2;
            else if (mc_done || ph == TO + 1) ph = 0;
            else ph++;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        eval_cycle("rst");
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        // Reset with forwarding and branch hits present: everything must read 0.
        rd_M = 5'd3; regWrite_M = 1; rs1_E = 5'd3; PCSrctE = 1;
        do_reset();
        check("rst_fwdA_zero", 32'(FowardAE), 32'd0);

        // Forwarding: M beats W, then W only when rd_M is x0.
        clear_inputs();
        rd_M = 5'd5; regWrite_M = 1; rd_W = 5'd5; regWrite_W = 1; rs1_E = 5'd5; rs2_E = 5'd0;
        eval_cycle("fwd_m");
        check("fwd_m_A", 32'(FowardAE), 32'd2);
        check("fwd_m_B", 32'(FowardBE), 32'd0);
        next_cycle();
        rd_M = 5'd0;
        eval_cycle("fwd_w");
        check("fwd_w_A", 32'(FowardAE), 32'd1);
        next_cycle();

        // Load-use: one stall cycle, then none with rd_E = x0.
        clear_inputs();
        memRead_E = 1; rd_E = 5'd7; rs2_D = 5'd7;
        eval_cycle("lu");
        check("lu_stall", 32'({StallF, StallD, FlushE}), 32'h7);
        next_cycle();
        memRead_E = 0;
        eval_cycle("lu_after");
        check("lu_once", 32'(StallF), 32'd0);
        next_cycle();
        memRead_E = 1; rd_E = 5'd0; rs2_D = 5'd0;
        eval_cycle("lu_x0");
        check("lu_x0_nostall", 32'(StallF), 32'd0);
        next_cycle();

        // Branch priority over mc_req and load-use.
        clear_inputs();
        PCSrctE = 1; mc_req_E = 1; memRead_E = 1; rd_E = 5'd4; rs1_D = 5'd4;
        eval_cycle("br");
        check("br_flush", 32'({FlushD, FlushE, StallF, mc_start}), 32'hC);
        next_cycle();
        clear_inputs();
        eval_cycle("br_after");
        check("br_idle", 32'(state_dbg), 32'd0);
        check("br_nostart", 32'(mc_start), 32'd0);
        next_cycle();

        // Multi-cycle op with mc_done at T+6.
        mc_req_E = 1;
        eval_cycle("mc_T");
        next_cycle();
        mc_req_E = 0;
        for (int k = 1; k <= 7; k++) begin
            mc_done = (k == 6);
            eval_cycle("mc");
            check("mc_start_k", 32'(mc_start), 32'(k == 1));
            check("mc_stall_k", 32'({StallF, StallE, FlushM}), (k <= 6) ? 32'h7 : 32'h0);
            next_cycle();
        end
        mc_done = 0;

        // Watchdog: no mc_done, abort at T+1+TO.
        do_reset();
        clear_inputs();
        mc_req_E = 1;
        eval_cycle("wd_T");
        next_cycle();
        mc_req_E = 0;
        for (int k = 1; k <= TO + 1; k++) begin
            eval_cycle("wd");
            check("wd_abort_k", 32'(mc_abort), 32'(k == TO + 1));
            next_cycle();
        end
        eval_cycle("wd_after");
        check("wd_idle", 32'({mc_busy, StallF, mc_abort}), 32'd0);
`ifdef EX_HAZARD_PERF_CNT_EN
        check("wd_abort_cnt", 32'(abort_cnt), 32'd1);
        check("wd_stall_cnt", stall_cnt, 32'd9);
`endif
        next_cycle();

        // Reset mid-op at T+3.
        mc_req_E = 1;
        eval_cycle("rm_T");
        next_cycle();
        mc_req_E = 0;
        eval_cycle("rm_1"); next_cycle();
        eval_cycle("rm_2"); next_cycle();
        #1;
        rst_n = 1'b0;
        rd_M = 5'd2; regWrite_M = 1; rs2_E = 5'd2; PCSrctE = 1;
        #1;
        check("rm_zero_ctl", ctl_vec(), 32'd0);
        check("rm_zero_fwd", 32'({FowardAE, FowardBE}), 32'd0);
        eval_cycle("rm_low");
        next_cycle();
        rst_n = 1'b1;
        clear_inputs();
        eval_cycle("rm_rel");
        check("rm_busy", 32'(mc_busy), 32'd0);
        next_cycle();
        mc_req_E = 1;
        eval_cycle("rm_req");
        next_cycle();
        mc_req_E = 0;
        eval_cycle("rm_start");
        check("rm_start", 32'(mc_start), 32'd1);
        next_cycle();

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            randomize_inputs();
            if (i == 400) begin
                #1 rst_n = 1'b0;
            end else if (i == 402) begin
                rst_n = 1'b1;
            end
            eval_cycle("rand");
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end
endmodule
